fetch_stage: RTL
================

Name: fetch_stage

Overview:
- Instruction-fetch stage of the 5-stage pipeline. It owns the PC register, the I-cache request interface and the IF/ID pipeline latch.
- It consumes the hazard unit's PC_EN / IF_EN / IF_FLUSH / pr_halt controls and the redirect targets from decode (J/JAL, JR) and MEM (taken branch).
- It produces the fetched instruction, its PC and PC+4 for the decode stage.
- It holds any redirect that arrives while the PC is stalled, and counts retired fetches.

Parameters:
- PC_INIT, 32'h0000_0000, PC value loaded on reset.
- CNT_W, 32, width of the fetch counter.

Ports:
- CLK  in  1  clock
- nRST  in  1  reset
- PC_EN  in  1  PC update enable (hazard unit)
- IF_EN  in  1  IF/ID latch enable (hazard unit)
- IF_FLUSH  in  1  IF/ID latch flush (hazard unit)
- pr_halt  in  1  halt request (hazard unit)
- PCSrc  in  1  taken branch resolved in MEM
- br_target  in  32  branch target
- ID_JR  in  1  JR in decode
- jr_target  in  32  register target for JR
- cu_Jump  in  1  J/JAL in decode
- j_target  in  32  jump target
- ihit  in  1  I-cache hit
- iload  in  32  I-cache read data
- iREN  out  1  I-cache read enable
- imemaddr  out  32  I-cache address
- IF_instr  out  32  latched instruction
- IF_pc  out  32  latched PC
- IF_npc  out  32  latched PC+4
- IF_valid  out  1  latched instruction is valid
- halted  out  1  fetch stage halted
- fetch_cnt  out  CNT_W  instructions accepted into IF/ID

Behaviour:
- Reset: nRST is asynchronous and active-low, clock is CLK.
  - All outputs return to reset values immediately, including mid-miss or mid-pending.
  - Reset values: PC=PC_INIT, imemaddr=PC_INIT, iREN=1, IF_instr=0, IF_pc=0, IF_npc=0, IF_valid=0, halted=0, fetch_cnt=0.
  - State resets to RUN and pending redirect is cleared.
- Targets: every target has bits[1:0] forced to 0. PC+4 wraps modulo 2^32 (32'hFFFF_FFFC+4=0).
- Redirect priority: PCSrc > ID_JR > cu_Jump > sequential (PC+4).
- State RUN:
  - iREN=1, imemaddr=PC.
  - Redirect with PC_EN=1: PC<=target next edge.
  - Redirect with PC_EN=0: capture target into pend_tgt and the source into pend_br (1 if PCSrc); go to PEND; PC holds.
  - No redirect, PC_EN=1, ihit=1: PC<=PC+4.
  - PC_EN=0, or ihit=0 with no redirect: PC holds.
- State PEND:
  - iREN=0 (no wrong-path fetch), imemaddr=PC.
  - A new PCSrc replaces pend_tgt and sets pend_br=1.
  - A new JR/Jump replaces pend_tgt only when pend_br=0.
  - When PC_EN=1: PC<=pend_tgt (or the same-cycle PCSrc target if asserted), clear pending, go to RUN.
- State HALT:
  - Entered from any state the edge after pr_halt=1.
  - iREN=0, halted=1, PC frozen, IF/ID latch frozen with IF_valid forced 0.
  - All inputs ignored; only reset exits.
  - pr_halt has priority over a same-cycle redirect.
- IF/ID latch, applied in priority order:
  - IF_FLUSH=1: instr/pc/npc<=0, valid<=0. Flush dominates IF_EN.
  - Else if IF_EN=1: instr<=iload, pc<=PC, npc<=PC+4, valid<=ihit & (state==RUN).
  - Else: hold.
- fetch_cnt:
  - Increments by 1 on the edge where IF_EN=1, IF_FLUSH=0, ihit=1 and state==RUN.
  - Wraps at 2^CNT_W.
- Latency: the instruction at PC appears on IF_instr one edge after ihit with IF_EN=1.
- Combinational outputs: iREN and imemaddr are combinational from state and PC. All other outputs are registered.

Test Plan:
- Reset with PC_INIT=32'h100: ihit=1 for 3 cycles with enables high and iload=A,B,C -> IF_pc=100,104,108; IF_instr=A,B,C; fetch_cnt=3.
- ihit=0 for 4 cycles at PC=0x200 (hazard drives PC_EN=0, IF_FLUSH=1), then ihit=1 -> PC holds 0x200; IF_valid=0 during the miss; the next latched IF_pc is 0x200; fetch_cnt increments once.
- PCSrc=1 with br_target=0x403 and cu_Jump=1 with j_target=0x800 in the same cycle -> PC=0x400 next edge; the IF/ID latch is flushed.
- cu_Jump with j_target=0x300 while PC_EN=0 for 2 cycles, then PCSrc with br_target=0x500 while still stalled, then PC_EN=1 -> iREN=0 during PEND; PC becomes 0x500.
- PCSrc with br_target=0x500 pending, then a JR to 0x600 while still stalled, then PC_EN=1 -> PC becomes 0x500 (the JR does not override a pending branch).
- pr_halt=1 with PCSrc=1 in the same cycle -> next edge halted=1, iREN=0, IF_valid=0, PC unchanged; further stimulus has no effect; nRST low mid-halt -> PC=PC_INIT, halted=0, iREN=1 immediately.

Source files
------------

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : fetch_stage
// Purpose  : Instruction-fetch stage of the 5-stage pipeline. Owns the PC
//            register, the I-cache request interface and the IF/ID latch.
//            A redirect that arrives while the PC is stalled is held
//            (state PEND) until the PC is released. Taken branches from MEM
//            outrank jumps from decode, both on arrival and while pending.
//            pr_halt freezes the stage until reset.
// Ports    : CLK, nRST (async, active-low)
//            PC_EN, IF_EN, IF_FLUSH, pr_halt    hazard-unit controls
//            PCSrc/br_target, ID_JR/jr_target,
//            cu_Jump/j_target                   redirect requests
//            ihit, iload / iREN, imemaddr       I-cache interface
//            IF_instr, IF_pc, IF_npc, IF_valid  IF/ID latch
//            halted, fetch_cnt                  status
// Revision : 1.0  initial release
// ============================================================================
module fetch_stage #(
   parameter logic [31:0] PC_INIT = 32'h0000_0000,
   parameter int          CNT_W   = 32
) (
   input  logic             CLK,
   input  logic             nRST,
   input  logic             PC_EN,
   input  logic             IF_EN,
   input  logic             IF_FLUSH,
   input  logic             pr_halt,
   input  logic             PCSrc,
   input  logic [31:0]      br_target,
   input  logic             ID_JR,
   input  logic [31:0]      jr_target,
   input  logic             cu_Jump,
   input  logic [31:0]      j_target,
   input  logic             ihit,
   input  logic [31:0]      iload,
   output logic             iREN,
   output logic [31:0]      imemaddr,
   output logic [31:0]      IF_instr,
   output logic [31:0]      IF_pc,
   output logic [31:0]      IF_npc,
   output logic             IF_valid,
   output logic             halted,
   output logic [CNT_W-1:0] fetch_cnt
);

   typedef enum logic [1:0] {
      RUN  = 2'd0,
      PEND = 2'd1,
      HALT = 2'd2
   } state_t;

   state_t      state, next_state;
   logic [31:0] pc, next_pc;
   logic [31:0] pend_tgt, next_pend_tgt;
   logic        pend_br, next_pend_br;

   logic [31:0] pc_plus4;
   logic [31:0] br_al, jr_al, j_al;
   logic        redirect;
   logic [31:0] redir_tgt;
   logic        freeze;
   logic        run_hit;

   // Targets are word aligned; PC+4 wraps naturally at 32 bits.
   assign pc_plus4 = pc + 32'd4;
   assign br_al    = {br_target[31:2], 2'b00};
   assign jr_al    = {jr_target[31:2], 2'b00};
   assign j_al     = {j_target[31:2],  2'b00};

   assign redirect  = PCSrc | ID_JR | cu_Jump;
   assign redir_tgt = PCSrc ? br_al : (ID_JR ? jr_al : j_al);

   // pr_halt freezes everything on the edge it is seen, and HALT keeps it so.
   assign freeze  = pr_halt | (state == HALT);
   assign run_hit = ihit & (state == RUN);

   assign halted = (state == HALT);

   // ------------------------------------------------------------------
   // State / PC / pending-redirect registers
   // ------------------------------------------------------------------
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state    <= RUN;
         pc       <= PC_INIT;
         pend_tgt <= 32'd0;
         pend_br  <= 1'b0;
      end else begin
         state    <= next_state;
         pc       <= next_pc;
         pend_tgt <= next_pend_tgt;
         pend_br  <= next_pend_br;
      end
   end

   always_comb begin
      next_state    = state;
      next_pc       = pc;
      next_pend_tgt = pend_tgt;
      next_pend_br  = pend_br;
      iREN          = 1'b0;
      imemaddr      = pc;

      case (state)
         RUN: begin
            iREN = 1'b1;
            if (pr_halt) begin
               next_state = HALT;
            end else if (redirect) begin
               if (PC_EN) begin
                  next_pc = redir_tgt;
               end else begin
                  next_pend_tgt = redir_tgt;
                  next_pend_br  = PCSrc;
                  next_state    = PEND;
               end
            end else if (PC_EN && ihit) begin
               next_pc = pc_plus4;
            end
         end

         PEND: begin
            // No fetch while a redirect is waiting: anything fetched now
            // would be on the wrong path.
            if (pr_halt) begin
               next_state = HALT;
            end else begin
               if (PCSrc) begin
                  next_pend_tgt = br_al;
                  next_pend_br  = 1'b1;
               end else if ((ID_JR || cu_Jump) && !pend_br) begin
                  next_pend_tgt = ID_JR ? jr_al : j_al;
               end
               if (PC_EN) begin
                  next_pc       = PCSrc ? br_al : pend_tgt;
                  next_pend_tgt = 32'd0;
                  next_pend_br  = 1'b0;
                  next_state    = RUN;
               end
            end
         end

         HALT: begin
            next_state = HALT;
         end

         default: begin
            next_state = RUN;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // IF/ID latch
   // ------------------------------------------------------------------
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         IF_instr <= 32'd0;
         IF_pc    <= 32'd0;
         IF_npc   <= 32'd0;
         IF_valid <= 1'b0;
      end else if (freeze) begin
         IF_valid <= 1'b0;
      end else if (IF_FLUSH) begin
         IF_instr <= 32'd0;
         IF_pc    <= 32'd0;
         IF_npc   <= 32'd0;
         IF_valid <= 1'b0;
      end else if (IF_EN) begin
         IF_instr <= iload;
         IF_pc    <= pc;
         IF_npc   <= pc_plus4;
         IF_valid <= run_hit;
      end
   end

   // ------------------------------------------------------------------
   // Fetch counter: valid instructions accepted into IF/ID
   // ------------------------------------------------------------------
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         fetch_cnt <= '0;
      end else if (!freeze && IF_EN && !IF_FLUSH && run_hit) begin
         fetch_cnt <= fetch_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

endmodule
`default_nettype wire
